// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master (AR + R) between the IFU refill path (requester 0)
// and the LSU load path (requester 1). One whole transaction is in flight at a time.
module axi_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic [1:0]        grant
);

  // Handshake rule on every channel: a transfer happens on a rising clock edge
  // where valid and ready are both high; valid and payload hold until then.

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   winner;
  logic   own_arvalid;
  logic   own_rready;
  logic   in_addr;
  logic   in_data;

  always_comb begin
    winner = lsu_arvalid;
    if (ifu_arvalid && lsu_arvalid) begin
      winner = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner_q;
    end
    own_arvalid  = owner_q ? lsu_arvalid : ifu_arvalid;
    own_rready   = owner_q ? lsu_rready  : ifu_rready;
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d = ADDR;
          owner_d = winner;
        end
      end
      ADDR: begin
        if (own_arvalid && m_arready) begin
          state_d      = DATA;
          last_owner_d = owner_q;
        end
      end
      DATA: begin
        // m_rlast alone ends the burst; arlen is never counted here.
        if (m_rvalid && own_rready && m_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  // Every handshake output is gated by a state flop, so requester valid never
  // reaches m_arvalid in the same cycle and reset clears them immediately.
  assign m_arvalid = in_addr & own_arvalid;
  assign m_araddr  = owner_q ? lsu_araddr  : ifu_araddr;
  assign m_arlen   = owner_q ? lsu_arlen   : ifu_arlen;
  assign m_arsize  = owner_q ? lsu_arsize  : ifu_arsize;
  assign m_arburst = owner_q ? lsu_arburst : ifu_arburst;

  assign ifu_arready = in_addr & ~owner_q & m_arready;
  assign lsu_arready = in_addr &  owner_q & m_arready;

  assign m_rready   = in_data & own_rready;
  assign ifu_rvalid = in_data & ~owner_q & m_rvalid;
  assign lsu_rvalid = in_data &  owner_q & m_rvalid;

  assign ifu_rdata = m_rdata;
  assign ifu_rresp = m_rresp;
  assign ifu_rlast = m_rlast;
  assign lsu_rdata = m_rdata;
  assign lsu_rresp = m_rresp;
  assign lsu_rlast = m_rlast;

  assign grant = (in_addr || in_data) ? {owner_q, ~owner_q} : 2'b00;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter: transaction-level arbitration model,
// per-requester expected-beat queues, plus a fixed-priority instance.
module tb_axi_rd_arbiter;

  localparam int MAIN_FP = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- main DUT (round robin) ----------------
  logic [1:0]  rq_arvalid;
  logic [31:0] rq_araddr  [2];
  logic [7:0]  rq_arlen   [2];
  logic [2:0]  rq_arsize  [2];
  logic [1:0]  rq_arburst [2];
  logic [1:0]  rq_rready;
  logic        m_arready, m_rvalid, m_rlast;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  wire         ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, ifu_rlast, lsu_rlast;
  wire  [31:0] ifu_rdata, lsu_rdata, m_araddr;
  wire  [1:0]  ifu_rresp, lsu_rresp, m_arburst, grant;
  wire         m_arvalid, m_rready;
  wire  [7:0]  m_arlen;
  wire  [2:0]  m_arsize;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(MAIN_FP)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(rq_arvalid[0]), .ifu_arready(ifu_arready), .ifu_araddr(rq_araddr[0]),
    .ifu_arlen(rq_arlen[0]), .ifu_arsize(rq_arsize[0]), .ifu_arburst(rq_arburst[0]),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(rq_rready[0]), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(rq_arvalid[1]), .lsu_arready(lsu_arready), .lsu_araddr(rq_araddr[1]),
    .lsu_arlen(rq_arlen[1]), .lsu_arsize(rq_arsize[1]), .lsu_arburst(rq_arburst[1]),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(rq_rready[1]), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .grant(grant)
  );

  // ---------------- fixed-priority DUT, constant stimulus ----------------
  logic        fp_ifu_arvalid = 1'b1, fp_lsu_arvalid = 1'b1;
  logic [31:0] fp_ifu_araddr = 32'h1000_0000, fp_lsu_araddr = 32'h2000_0000;
  logic [7:0]  fp_arlen = 8'd0;
  logic [2:0]  fp_arsize = 3'd2;
  logic [1:0]  fp_arburst = 2'd1;
  logic        fp_rready = 1'b1, fp_m_arready = 1'b1, fp_m_rvalid = 1'b1, fp_m_rlast = 1'b1;
  logic [31:0] fp_m_rdata = 32'hDEAD_BEEF;
  logic [1:0]  fp_m_rresp = 2'd0;
  wire         fp_ifu_arready, fp_lsu_arready, fp_ifu_rvalid, fp_lsu_rvalid;
  wire         fp_ifu_rlast, fp_lsu_rlast, fp_m_arvalid, fp_m_rready;
  wire  [31:0] fp_ifu_rdata, fp_lsu_rdata, fp_m_araddr;
  wire  [1:0]  fp_ifu_rresp, fp_lsu_rresp, fp_m_arburst, fp_grant;
  wire  [7:0]  fp_m_arlen;
  wire  [2:0]  fp_m_arsize;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset),
    .ifu_arvalid(fp_ifu_arvalid), .ifu_arready(fp_ifu_arready), .ifu_araddr(fp_ifu_araddr),
    .ifu_arlen(fp_arlen), .ifu_arsize(fp_arsize), .ifu_arburst(fp_arburst),
    .ifu_rvalid(fp_ifu_rvalid), .ifu_rready(fp_rready), .ifu_rdata(fp_ifu_rdata),
    .ifu_rresp(fp_ifu_rresp), .ifu_rlast(fp_ifu_rlast),
    .lsu_arvalid(fp_lsu_arvalid), .lsu_arready(fp_lsu_arready), .lsu_araddr(fp_lsu_araddr),
    .lsu_arlen(fp_arlen), .lsu_arsize(fp_arsize), .lsu_arburst(fp_arburst),
    .lsu_rvalid(fp_lsu_rvalid), .lsu_rready(fp_rready), .lsu_rdata(fp_lsu_rdata),
    .lsu_rresp(fp_lsu_rresp), .lsu_rlast(fp_lsu_rlast),
    .m_arvalid(fp_m_arvalid), .m_arready(fp_m_arready), .m_araddr(fp_m_araddr),
    .m_arlen(fp_m_arlen), .m_arsize(fp_m_arsize), .m_arburst(fp_m_arburst),
    .m_rvalid(fp_m_rvalid), .m_rready(fp_m_rready), .m_rdata(fp_m_rdata),
    .m_rresp(fp_m_rresp), .m_rlast(fp_m_rlast), .grant(fp_grant)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Beat content as a function of the request: {rlast, rresp, rdata}.
  function automatic logic [34:0] beat_of(input logic [31:0] a, input int b, input bit last);
    logic [31:0] d;
    logic [1:0]  r;
    d = (a + 32'(b) * 32'd4) ^ 32'h5A5A_0000;
    r = a[3:2] ^ b[1:0];
    return {last, r, d};
  endfunction

  logic [34:0] exp_q_ifu[$];
  logic [34:0] exp_q_lsu[$];

  // Transaction-level reference: who owns the master, whether its address has
  // been accepted yet, and who was granted most recently.
  int   mdl_owner = -1, nx_owner = -1;
  bit   mdl_ar = 1'b0, nx_ar = 1'b0;
  int   mdl_last = 1, nx_last = 1;
  bit   acc [2];
  int   req_pct = 30;

  // Memory-side responder.
  bit          sl_act = 1'b0;
  logic [31:0] sl_addr;
  int          sl_len, sl_beat;

  task automatic push_beats(input int o, input logic [31:0] a, input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      if (o == 0) exp_q_ifu.push_back(beat_of(a, b, b == int'(len)));
      else        exp_q_lsu.push_back(beat_of(a, b, b == int'(len)));
    end
  endtask

  task automatic check_and_model();
    bit          in_addr, in_data, exp_marv, exp_mrr;
    int          o;
    logic [1:0]  exp_grant;
    logic [34:0] got;
    in_addr   = (mdl_owner >= 0) && mdl_ar;
    in_data   = (mdl_owner >= 0) && !mdl_ar;
    o         = (mdl_owner < 0) ? 0 : mdl_owner;
    exp_grant = (in_addr || in_data) ? 2'(1 << o) : 2'b00;
    exp_marv  = in_addr && rq_arvalid[o];
    exp_mrr   = in_data && rq_rready[o];
    check("grant", grant, exp_grant);
    check("m_arvalid", m_arvalid, exp_marv);
    if (exp_marv) begin
      check("m_araddr", m_araddr, rq_araddr[o]);
      check("m_arlen", m_arlen, rq_arlen[o]);
      check("m_arsize", m_arsize, rq_arsize[o]);
      check("m_arburst", m_arburst, rq_arburst[o]);
    end
    check("ifu_arready", ifu_arready, in_addr && o == 0 && m_arready);
    check("lsu_arready", lsu_arready, in_addr && o == 1 && m_arready);
    check("m_rready", m_rready, exp_mrr);
    check("ifu_rvalid", ifu_rvalid, in_data && o == 0 && m_rvalid);
    check("lsu_rvalid", lsu_rvalid, in_data && o == 1 && m_rvalid);
    check("ifu_rfwd", {ifu_rlast, ifu_rresp, ifu_rdata}, {m_rlast, m_rresp, m_rdata});
    check("lsu_rfwd", {lsu_rlast, lsu_rresp, lsu_rdata}, {m_rlast, m_rresp, m_rdata});
    if (in_data && m_rvalid && rq_rready[o]) begin
      if (o == 0) begin
        got = {ifu_rlast, ifu_rresp, ifu_rdata};
        check("sb_ifu_avail", 64'(exp_q_ifu.size() != 0), 64'd1);
        if (exp_q_ifu.size() != 0) check("sb_ifu_beat", got, exp_q_ifu.pop_front());
      end else begin
        got = {lsu_rlast, lsu_rresp, lsu_rdata};
        check("sb_lsu_avail", 64'(exp_q_lsu.size() != 0), 64'd1);
        if (exp_q_lsu.size() != 0) check("sb_lsu_beat", got, exp_q_lsu.pop_front());
      end
    end
    // Next transaction-level state.
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    nx_owner = mdl_owner;
    nx_ar    = mdl_ar;
    nx_last  = mdl_last;
    if (mdl_owner < 0) begin
      if (rq_arvalid != 2'b00) begin
        if (rq_arvalid == 2'b11) nx_owner = (MAIN_FP != 0) ? 1 : 1 - mdl_last;
        else                     nx_owner = rq_arvalid[1] ? 1 : 0;
        nx_ar = 1'b1;
      end
    end else if (mdl_ar) begin
      if (exp_marv && m_arready) begin
        nx_ar   = 1'b0;
        nx_last = o;
        acc[o]  = 1'b1;
        push_beats(o, rq_araddr[o], rq_arlen[o]);
      end
    end else if (m_rvalid && exp_mrr && m_rlast) begin
      nx_owner = -1;
    end
    // Responder bookkeeping for the coming edge.
    if (m_arvalid && m_arready) begin
      sl_act  = 1'b1;
      sl_addr = m_araddr;
      sl_len  = int'(m_arlen);
      sl_beat = 0;
    end else if (sl_act && m_rvalid && m_rready) begin
      if (sl_beat == sl_len) sl_act = 1'b0;
      else                   sl_beat++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    mdl_owner = nx_owner;
    mdl_ar    = nx_ar;
    mdl_last  = nx_last;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) rq_arvalid[i] = 1'b0;
      if (!rq_arvalid[i] && $urandom_range(0, 99) < req_pct) begin
        rq_arvalid[i] = 1'b1;
        rq_araddr[i]  = $urandom;
        rq_arlen[i]   = 8'($urandom_range(0, 3));
        rq_arsize[i]  = 3'($urandom_range(0, 2));
        rq_arburst[i] = 2'($urandom_range(0, 2));
      end
      rq_rready[i] = ($urandom_range(0, 99) < 70);
    end
    m_arready = !sl_act && ($urandom_range(0, 99) < 60);
    m_rvalid  = 1'b0;
    m_rdata   = $urandom;
    m_rresp   = 2'($urandom_range(0, 3));
    m_rlast   = 1'($urandom_range(0, 1));
    if (sl_act && $urandom_range(0, 99) < 60) begin
      {m_rlast, m_rresp, m_rdata} = beat_of(sl_addr, sl_beat, sl_beat == sl_len);
      m_rvalid = 1'b1;
    end
    @(negedge clock);
    check_and_model();
  endtask

  // A requester must not withdraw arvalid before its address is accepted.
  logic [1:0] ar_hold;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ar_hold <= 2'b00;
    end else begin
      if ((ar_hold & ~rq_arvalid) != 2'b00) $error("requester dropped arvalid before arready");
      ar_hold <= rq_arvalid & ~{lsu_arready, ifu_arready};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fp_lsu_cnt;
    bit  found;
    rq_arvalid = 2'b11;
    rq_rready  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      rq_araddr[i] = 32'h3000_0000; rq_arlen[i] = 8'd0; rq_arsize[i] = 3'd2; rq_arburst[i] = 2'd1;
    end
    m_arready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'd0;

    // Reset state with every input asking for activity.
    repeat (2) @(negedge clock);
    check("rst_grant", grant, 2'b00);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_rready", m_rready, 1'b0);
    check("rst_arready", {lsu_arready, ifu_arready}, 2'b00);
    check("rst_rvalid", {lsu_rvalid, ifu_rvalid}, 2'b00);
    check("rst_fp_grant", fp_grant, 2'b00);
    rq_arvalid = 2'b00;
    rq_rready  = 2'b00;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    reset      = 1'b0;

    // Fixed priority with both requesters always valid: LSU owns every slot.
    fp_lsu_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      check("fp_ifu_arready", fp_ifu_arready, 1'b0);
      check("fp_grant_ifu", fp_grant[0], 1'b0);
      if (fp_m_arvalid) check("fp_m_araddr", fp_m_araddr, 32'h2000_0000);
      if (fp_lsu_arready) fp_lsu_cnt++;
    end
    check("fp_lsu_grants", fp_lsu_cnt, 3);

    // Random traffic, round robin.
    for (int c = 0; c < 1500; c++) step();

    // Asynchronous reset in the middle of a burst.
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      step();
      found = (nx_owner >= 0) && !nx_ar && sl_act && sl_beat == 1 && sl_len >= 2;
    end
    check("rst_window_found", found, 1'b1);
    @(posedge clock);
    #1;
    rq_rready = 2'b11;
    m_rvalid  = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_grant", grant, 2'b00);
    check("async_rst_m_arvalid", m_arvalid, 1'b0);
    check("async_rst_m_rready", m_rready, 1'b0);
    check("async_rst_rvalid", {lsu_rvalid, ifu_rvalid}, 2'b00);
    rq_arvalid = 2'b00;
    rq_rready  = 2'b00;
    m_rvalid   = 1'b0;
    m_arready  = 1'b0;
    exp_q_ifu.delete();
    exp_q_lsu.delete();
    sl_act    = 1'b0;
    mdl_owner = -1; nx_owner = -1;
    mdl_ar    = 1'b0; nx_ar = 1'b0;
    mdl_last  = 1; nx_last = 1;
    acc[0]    = 1'b0;
    acc[1]    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int c = 0; c < 800; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI4 read master (AR + R channels) between the instruction-fetch path (ICACHE refill, requester 0) and the LSU load path (requester 1).
- Sits between the IFU/LSU read ports and the core's top-level io_master read channels.
- Serialises whole transactions (single beat or burst); only one read is outstanding at a time.
- Supports round-robin or fixed LSU-priority arbitration.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- FIXED_PRIO, 0, 0 = round-robin between IFU and LSU; 1 = LSU always wins ties

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- ifu_arvalid  in  1  IFU read-address valid
- ifu_arready  out  1  IFU read-address accepted
- ifu_araddr  in  ADDR_W  IFU address
- ifu_arlen  in  8  IFU burst length minus 1
- ifu_arsize  in  3  IFU beat size
- ifu_arburst  in  2  IFU burst type
- ifu_rvalid  out  1  IFU read data valid
- ifu_rready  in  1  IFU read data ready
- ifu_rdata  out  DATA_W  IFU read data
- ifu_rresp  out  2  IFU response
- ifu_rlast  out  1  IFU last beat
- lsu_arvalid, lsu_arready, lsu_araddr, lsu_arlen, lsu_arsize, lsu_arburst, lsu_rvalid, lsu_rready, lsu_rdata, lsu_rresp, lsu_rlast: same as the ifu_* ports, for the LSU
- m_arvalid  out  1  master read-address valid
- m_arready  in  1  master read-address ready
- m_araddr  out  ADDR_W  master address
- m_arlen  out  8  master burst length
- m_arsize  out  3  master beat size
- m_arburst  out  2  master burst type
- m_rvalid  in  1  master read data valid
- m_rready  out  1  master read data ready
- m_rdata  in  DATA_W  master read data
- m_rresp  in  2  master response
- m_rlast  in  1  master last beat
- grant  out  2  one-hot current owner, for debug/perf: bit0 = IFU, bit1 = LSU

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, owner (1 bit), last_owner (1 bit).
- Reset:
  - Asynchronous; state = IDLE, owner = 0, last_owner = 1 (IFU wins first tie), grant = 0.
  - All valid/ready outputs are 0 while in IDLE.
- IDLE:
  - Samples ifu_arvalid / lsu_arvalid. If either is high, the next state is ADDR and owner latches the winner.
  - Only one requester valid: that requester wins.
  - Both valid, FIXED_PRIO = 1: LSU wins.
  - Both valid, FIXED_PRIO = 0: the requester that is not last_owner wins.
  - No combinational path from requester valid to m_arvalid; the first m_arvalid appears 1 cycle after the request.
- ADDR:
  - m_arvalid = owner's arvalid. m_araddr / arlen / arsize / arburst are muxed combinationally from the owner.
  - Owner's arready = m_arready; the non-owner's arready = 0.
  - On m_arvalid & m_arready: state = DATA, last_owner = owner.
- DATA:
  - Owner's rvalid = m_rvalid, and m_rready = owner's rready.
  - rdata / rresp / rlast are forwarded to both requesters; only the owner sees rvalid = 1. Non-owner rvalid = 0.
  - On m_rvalid & m_rready & m_rlast: state = IDLE. The next arbitration happens in that IDLE cycle, so there is a 1-cycle bubble between transactions.
  - A beat without rlast keeps the state in DATA (burst). arlen is not counted; m_rlast is authoritative.
- grant:
  - One-hot owner in ADDR and DATA; 0 in IDLE.
- Requester rules:
  - A requester must hold arvalid and AR fields stable until arready (AXI rule). The arbiter does not re-arbitrate in ADDR.
  - A requester that drops arvalid in ADDR before the handshake is a protocol violation; behaviour is unspecified and flagged by a bench assertion.
- Error responses: rresp != 0 is forwarded unchanged; the arbiter takes no other action.
- Reset mid-transaction: the state returns to IDLE immediately. Any outstanding master beats after reset are the system's responsibility; the arbiter drives m_rready = 0.

Test Plan:
- Single IFU read: ifu_arvalid with araddr = 0x3000_0000, arlen = 0 → m_arvalid rises 1 cycle later with the same addr. m_rdata = 0xDEADBEEF, rlast = 1 → ifu_rvalid = 1, ifu_rdata = 0xDEADBEEF, lsu_rvalid = 0, then IDLE.
- Simultaneous requests, FIXED_PRIO = 0, from reset: IFU is granted first. LSU is granted after IFU's rlast, following a 1-cycle IDLE bubble. A further simultaneous pair grants IFU again (alternation).
- Simultaneous requests, FIXED_PRIO = 1, LSU holding arvalid continuously for 3 transactions → LSU is granted 3 times and IFU is stalled (ifu_arready = 0) throughout.
- IFU burst, arlen = 3, with m_rvalid gaps and ifu_rready toggling → exactly 4 beats are delivered in order and the state leaves DATA only on the rlast beat. An LSU request arriving mid-burst waits.
- m_arready held low for 5 cycles → m_arvalid and araddr stay stable and the owner does not change, even if the other requester asserts.
- Async reset asserted mid-burst at beat 2 → m_arvalid = m_rready = 0 and grant = 0 without waiting for a clock edge. After release, a new LSU request is serviced normally.
